// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: serial line in, deframed bytes out on valid/ready,
// plus error pulses and a busy flag.
interface uart_rx_if;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  modport master (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun_err, busy
  );

  modport slave (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, registered valid/ready
// output with one-cycle framing and overrun error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~bus.rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Newest byte always wins; a pending unconsumed byte is flagged as lost.
            data_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~bus.rx_ready;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_err = overrun_q;
  assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed corner sequences, a vector table and a randomized byte stream
// checked against a byte-level model of the receiver's contract.
module tb_uart_rx;
  localparam int unsigned CPB     = 8;
  localparam int unsigned HALF    = CPB / 2;
  localparam int          NOM_LAT = 2 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic rst;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, rise_cyc = -1;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_err)   fe_cnt   <= fe_cnt + 1;
    if (bus.overrun_err) ov_cnt   <= ov_cnt + 1;
    if (bus.busy)        busy_cnt <= busy_cnt + 1;
    if (bus.rx_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= bus.rx_valid;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       consume;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[8];

  int   fe0, ov0, b0, c0, lat, lat_use, nb;
  logic       model_valid;
  logic [7:0] model_data;
  int         exp_fe, exp_ov;
  logic [7:0] rd;
  logic       rstop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first ncyc clock cycles of an 8N1 frame, starting at the current negedge.
  task automatic send_bits(input logic [7:0] d, input logic stop, input int unsigned ncyc);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < int'(ncyc); i++) begin
      bus.rx = frame[i / CPB];
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bits(d, stop, 10 * CPB);
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx       = 1'b1;
    bus.rx_ready = 1'b0;
    rst          = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic snap();
    idle(1);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    b0  = busy_cnt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0};
    vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'h55, 1, 0};
    vecs[2] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 0, 1};
    vecs[3] = '{8'h34, 1'b1, 1'b1, 1'b1, 8'h34, 0, 1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 0, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0, 0};
    vecs[7] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 0, 1};

    bus.rx = 1'b1;
    bus.rx_ready = 1'b0;
    rst = 1'b1;
    idle(3);
    check("reset rx_valid", bus.rx_valid, 0);
    check("reset rx_data", bus.rx_data, 0);
    check("reset frame_err", bus.frame_err, 0);
    check("reset overrun_err", bus.overrun_err, 0);
    check("reset busy", bus.busy, 0);
    rst = 1'b0;
    idle(2);

    // Single byte, latency window, then one-cycle consume.
    snap();
    c0 = cyc;
    send_byte(8'h55, 1'b1);
    idle(2);
    lat = rise_cyc - c0;
    check("0x55 rx_valid", bus.rx_valid, 1);
    check("0x55 rx_data", bus.rx_data, 8'h55);
    check("0x55 latency in window", (lat >= NOM_LAT - 1) && (lat <= NOM_LAT + 4), 1);
    check("0x55 no frame_err", fe_cnt - fe0, 0);
    check("0x55 no overrun_err", ov_cnt - ov0, 0);
    consume();
    check("consume clears rx_valid", bus.rx_valid, 0);
    lat_use = ((lat >= NOM_LAT - 1) && (lat <= NOM_LAT + 4)) ? lat : NOM_LAT + 1;

    // Two-cycle glitch on the line.
    snap();
    bus.rx = 1'b0;
    idle(2);
    bus.rx = 1'b1;
    idle(2 * CPB);
    check("glitch busy seen", (busy_cnt - b0) != 0, 1);
    check("glitch back idle", bus.busy, 0);
    check("glitch no rx_valid", bus.rx_valid, 0);
    check("glitch no frame_err", fe_cnt - fe0, 0);
    send_byte(8'h3C, 1'b1);
    idle(2);
    check("after glitch rx_data", bus.rx_data, 8'h3C);
    check("after glitch rx_valid", bus.rx_valid, 1);
    consume();

    // Bad stop bit right after reset.
    do_reset();
    snap();
    send_byte(8'hA5, 1'b0);
    bus.rx = 1'b1;
    idle(3 * CPB);
    check("bad stop frame_err count", fe_cnt - fe0, 1);
    check("bad stop rx_valid", bus.rx_valid, 0);
    check("bad stop rx_data", bus.rx_data, 0);
    check("bad stop busy", bus.busy, 0);

    // Back-to-back with no consumer: overrun.
    do_reset();
    snap();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(2);
    check("overrun count", ov_cnt - ov0, 1);
    check("overrun rx_data", bus.rx_data, 8'h34);
    check("overrun rx_valid", bus.rx_valid, 1);

    // Back-to-back with consume landing on the completion edge: no overrun.
    do_reset();
    snap();
    fork
      begin
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
      end
      begin
        idle(10 * CPB + lat_use - 1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    idle(2);
    check("simultaneous consume no overrun", ov_cnt - ov0, 0);
    check("simultaneous consume rx_data", bus.rx_data, 8'h34);
    check("simultaneous consume rx_valid", bus.rx_valid, 1);

    // Reset in the middle of data bit 4 with a byte pending.
    do_reset();
    send_byte(8'h5A, 1'b1);
    idle(2);
    snap();
    send_bits(8'hC3, 1'b1, 5 * CPB + CPB / 2);
    rst = 1'b1;
    #1;
    check("mid reset rx_valid", bus.rx_valid, 0);
    check("mid reset rx_data", bus.rx_data, 0);
    check("mid reset busy", bus.busy, 0);
    check("mid reset frame_err", bus.frame_err, 0);
    check("mid reset overrun_err", bus.overrun_err, 0);
    @(negedge clk);
    bus.rx = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2 * CPB);
    check("mid reset no error after release", fe_cnt - fe0, 0);
    send_byte(8'hC3, 1'b1);
    idle(2);
    check("after reset rx_data", bus.rx_data, 8'hC3);
    check("after reset rx_valid", bus.rx_valid, 1);
    consume();

    // Break: line low for 30 bit times.
    do_reset();
    snap();
    nb = 0;
    bus.rx = 1'b0;
    for (int i = 0; i < int'(30 * CPB); i++) begin
      @(negedge clk);
      if (i >= 4 && !bus.busy) nb++;
    end
    check("break busy held", nb, 0);
    bus.rx = 1'b1;
    idle(2 * CPB);
    check("break single frame_err", fe_cnt - fe0, 1);
    check("break rx_valid", bus.rx_valid, 0);
    send_byte(8'h0F, 1'b1);
    idle(2);
    check("after break rx_data", bus.rx_data, 8'h0F);
    check("after break rx_valid", bus.rx_valid, 1);

    // Vector table.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      snap();
      send_byte(vecs[v].data, vecs[v].stop);
      bus.rx = 1'b1;
      idle(CPB);
      check($sformatf("vec%0d rx_valid", v), bus.rx_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d rx_data", v), bus.rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("vec%0d overrun_err", v), ov_cnt - ov0, vecs[v].exp_ov);
      if (vecs[v].consume) consume();
      idle(CPB);
    end

    // Randomized stream against a byte-level model.
    do_reset();
    snap();
    model_valid = 1'b0;
    model_data  = 8'h00;
    exp_fe      = 0;
    exp_ov      = 0;
    for (int n = 0; n < 40; n++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      send_byte(rd, rstop);
      bus.rx = 1'b1;
      if (rstop) begin
        if (model_valid) exp_ov++;
        model_valid = 1'b1;
        model_data  = rd;
      end else begin
        exp_fe++;
      end
      idle(2);
      check($sformatf("rand%0d rx_valid", n), bus.rx_valid, model_valid);
      check($sformatf("rand%0d rx_data", n), bus.rx_data, model_data);
      if ($urandom_range(0, 1) != 0) begin
        consume();
        model_valid = 1'b0;
      end
      idle($urandom_range(rstop ? 0 : CPB, 2 * CPB));
    end
    idle(2);
    check("rand frame_err total", fe_cnt - fe0, exp_fe);
    check("rand overrun_err total", ov_cnt - ov0, exp_ov);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver for the DE10 UART subsystem. It is the receive-side counterpart of the transmit controller path.
- Samples the asynchronous rx line and deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop).
- Presents each byte on a valid/ready interface to a consumer.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range >= 4.
HALF_BIT, CLKS_PER_BIT/2, mid-bit offset used for start-bit validation (integer division).

Ports:
clk  input  1  system clock
rst  input  1  reset: asynchronous, active-high
rx  input  1  serial line, asynchronous to clk, idle high
rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1
rx_data  output  8  last correctly framed byte
rx_valid  output  1  rx_data holds an unconsumed byte (level)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: new byte completed while previous byte unconsumed
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): both synchronizer flops = 1; state = IDLE; rx_data = 0; rx_valid = 0; frame_err = 0; overrun_err = 0; busy = 0; bit counter, bit index and shift register = 0.
- Synchronizer: rx passes through 2 flops to produce rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Counter width is clog2(CLKS_PER_BIT).
- IDLE: when rx_s = 0, go to START with counter = 0.
- START: count to HALF_BIT-1, then sample rx_s.
  - rx_s = 0: go to DATA with counter = 0 and index = 0.
  - rx_s = 1: glitch; return to IDLE. No output activity.
- DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[index].
  - Reset counter and increment index.
  - After index 7 is sampled, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s = 1: on the next edge, rx_data <= shift and rx_valid <= 1. Go to IDLE.
  - rx_s = 0: on the next edge, frame_err = 1 for one cycle. rx_data and rx_valid are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE.
  - A held-low line (break) produces exactly one frame_err.
- Handshake: rx_valid clears on the edge where rx_valid = 1 and rx_ready = 1. rx_ready has no effect while rx_valid = 0.
- Overrun: a good stop bit while rx_valid = 1 and rx_ready = 0:
  - rx_data is overwritten with the new byte;
  - rx_valid stays 1;
  - overrun_err pulses for one cycle.
- Simultaneous good stop bit and consume (rx_valid = 1, rx_ready = 1): no overrun. rx_valid stays 1 with the new byte.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1..2 cycles after the start edge at the rx pin. Benches allow ±2 cycles.
- Back-to-back characters: the next start bit may begin immediately after the stop bit. The receiver is back in IDLE at mid stop bit, so no character is lost.
- Reset mid-character: returns immediately to reset values. The partial byte is discarded and no error is flagged.
- Outputs are registered; no combinational path from rx or rx_ready to any output.

Test Plan:
- CLKS_PER_BIT=8; send 0x55 with valid stop bit, rx_ready=0 -> rx_valid=1, rx_data=0x55, no error pulses; then rx_ready=1 for 1 cycle -> rx_valid=0 next cycle.
- Drive rx low for 2 cycles then high -> busy pulses briefly; no rx_valid, no frame_err; FSM back in IDLE; a following byte 0x3C is received correctly.
- Send 0xA5 with stop bit = 0, then hold line high -> exactly one frame_err pulse; rx_valid stays 0; rx_data unchanged (0x00 after reset).
- Send 0x12 then 0x34 back-to-back with rx_ready=0 -> overrun_err pulses once at the second byte; rx_data=0x34; rx_valid=1. Repeat with rx_ready=1 in the completion cycle -> no overrun_err.
- Assert rst in the middle of data bit 4 of a byte -> all outputs at reset values next cycle; after release, byte 0xC3 is received correctly.
- Hold rx low for 30 bit times, then high, then send 0x0F -> one frame_err only; busy stays high while low; then rx_data=0x0F, rx_valid=1.
